ext_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle immediate extender, for the pipelined CPU. Accepts a raw operand plus mode under a valid/ready handshake and returns the extended result two cycles later. Supports the existing immediate modes (zero-extend, sign-extend, shift-to-upper) at any data and immediate width. Can also extract and extend byte, half and word load data from a memory word, so the same block serves both the decode and the memory-writeback stage.

---
 rtl/ext_pipe_pkg.sv | 18 +
 rtl/ext_pipe_core.sv | 60 ++++++
 rtl/ext_pipe.sv | 94 +++++++++
 tb/tb_ext_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pipe_pkg.sv
// ext_pipe_pkg: mode encodings shared by the extender pipeline and its datapath.
// Optional feature macro: EXTP_LOADEXT_EN (load byte/half/word extraction).
package ext_pipe_pkg;

   localparam int EXTP_MODE_W = 3;

   typedef enum logic [EXTP_MODE_W-1:0] {
      EXTP_UNSIGNED = 3'd0,
      EXTP_SIGNED   = 3'd1,
      EXTP_SHIFT    = 3'd2,
      EXTP_LB_S     = 3'd3,
      EXTP_LB_U     = 3'd4,
      EXTP_LH_S     = 3'd5,
      EXTP_LH_U     = 3'd6,
      EXTP_WORD     = 3'd7
   } extp_mode_e;

endpackage

// File: rtl/ext_pipe_core.sv
// ext_pipe_core: combinational extend/extract datapath between the two pipeline stages.
// With EXTP_LOADEXT_EN defined, byte/half/word load extraction is built; otherwise
// the load modes report Error=1 with a zero result and no extraction logic exists.
module ext_pipe_core
   import ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  offset,
   input  extp_mode_e        mode,
   output logic [DATA_W-1:0] result,
   output logic              error
);

   logic [IMM_W-1:0] imm;
   assign imm = data[IMM_W-1:0];

`ifdef EXTP_LOADEXT_EN
   // Little-endian lane select: the addressed byte lands in bits [7:0].
   logic [DATA_W-1:0] lane;
   assign lane = data >> {offset, 3'b000};
`else
   logic unused_load;
   assign unused_load = ^{data[DATA_W-1:IMM_W], offset};
`endif

   // Select the extension for the current mode; any error forces a zero result.
   always_comb begin
      result = '0;
      error  = 1'b0;
      case (mode)
         EXTP_UNSIGNED: result = DATA_W'(imm);
         EXTP_SIGNED:   result = DATA_W'($signed(imm));
         EXTP_SHIFT:    result = {imm, {(DATA_W-IMM_W){1'b0}}};
`ifdef EXTP_LOADEXT_EN
         EXTP_LB_S:     result = DATA_W'($signed(lane[7:0]));
         EXTP_LB_U:     result = DATA_W'(lane[7:0]);
         EXTP_LH_S: begin
            error  = offset[0];
            result = DATA_W'($signed(lane[15:0]));
         end
         EXTP_LH_U: begin
            error  = offset[0];
            result = DATA_W'(lane[15:0]);
         end
         // For a 32-bit datapath the only 4-aligned offset is 0, so one test covers both widths.
         EXTP_WORD: begin
            error  = (offset[1:0] != 2'b00);
            result = DATA_W'($signed(lane[31:0]));
         end
`endif
         default:       error = 1'b1;
      endcase
      if (error) result = '0;
   end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage valid/ready immediate and load-data extender.
// S1 holds the raw operand, S2 holds the extended result. Build option
// EXTP_LOADEXT_EN enables load extraction modes in ext_pipe_core.
module ext_pipe
   import ext_pipe_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  IMM_W  = 16,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   EXTP_Flush,
   input  logic                   EXTP_InValid,
   output logic                   EXTP_InReady,
   input  logic [DATA_W-1:0]      EXTP_Input,
   input  logic [OFF_W-1:0]       EXTP_Offset,
   input  logic [EXTP_MODE_W-1:0] EXTP_Mode,
   output logic                   EXTP_OutValid,
   input  logic                   EXTP_OutReady,
   output logic [DATA_W-1:0]      EXTP_Output,
   output logic                   EXTP_Error
);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [OFF_W-1:0]  s1_offset;
   extp_mode_e        s1_mode;
   logic              s2_valid;
   logic [DATA_W-1:0] s2_result;
   logic              s2_error;
   logic [DATA_W-1:0] core_result;
   logic              core_error;
   logic              s2_adv;
   logic              s1_adv;
   logic              accept;

   // An empty S2 always advances, so S1 advancing reduces to S2 advancing.
   assign s2_adv       = !s2_valid || EXTP_OutReady;
   assign s1_adv       = s2_adv;
   assign EXTP_InReady = reset && (!s1_valid || s1_adv);
   assign accept       = EXTP_InValid && EXTP_InReady;

   // Capture the operand on accept; payload needs no reset since valid qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_data   <= EXTP_Input;
         s1_offset <= EXTP_Offset;
         s1_mode   <= extp_mode_e'(EXTP_Mode);
      end
   end

   ext_pipe_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .OFF_W  (OFF_W)
   ) u_core (
      .data   (s1_data),
      .offset (s1_offset),
      .mode   (s1_mode),
      .result (core_result),
      .error  (core_error)
   );

   // Valid bits and S2 result; flush drops everything in flight, reset also zeroes outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_error  <= 1'b0;
      end else if (EXTP_Flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (accept)
            s1_valid <= 1'b1;
         else if (s1_adv)
            s1_valid <= 1'b0;
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_result <= core_result;
               s2_error  <= core_error;
            end
         end
      end
   end

   assign EXTP_OutValid = s2_valid;
   assign EXTP_Output   = s2_result;
   assign EXTP_Error    = s2_error;

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: table-driven and directed bench for ext_pipe (32-bit and 64-bit instances).
// Expectations for load modes follow the EXTP_LOADEXT_EN build setting.
`timescale 1ns/1ps
module tb_ext_pipe;
   import ext_pipe_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid, out_err;
   logic [31:0] din, dout;
   logic [1:0]  off;
   logic [2:0]  mode;

   logic        flush64, in_valid64, out_ready64;
   logic        in_ready64, out_valid64, out_err64;
   logic [63:0] din64, dout64;
   logic [2:0]  off64, mode64;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;

   ext_pipe #(.DATA_W(32), .IMM_W(16)) dut (
      .clk(clk), .reset(reset), .EXTP_Flush(flush),
      .EXTP_InValid(in_valid), .EXTP_InReady(in_ready),
      .EXTP_Input(din), .EXTP_Offset(off), .EXTP_Mode(mode),
      .EXTP_OutValid(out_valid), .EXTP_OutReady(out_ready),
      .EXTP_Output(dout), .EXTP_Error(out_err)
   );

   ext_pipe #(.DATA_W(64), .IMM_W(16)) dut64 (
      .clk(clk), .reset(reset), .EXTP_Flush(flush64),
      .EXTP_InValid(in_valid64), .EXTP_InReady(in_ready64),
      .EXTP_Input(din64), .EXTP_Offset(off64), .EXTP_Mode(mode64),
      .EXTP_OutValid(out_valid64), .EXTP_OutReady(out_ready64),
      .EXTP_Output(dout64), .EXTP_Error(out_err64)
   );

   typedef struct {
      logic [2:0]  mode;
      logic [1:0]  off;
      logic [31:0] din;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   typedef struct {
      logic [63:0] exp;
      logic        err;
   } sb_t;

   vec_t vecs[14];
   sb_t  sbq[$];

   function automatic sb_t model_adj(input logic [2:0] m, input logic [63:0] e, input logic er);
      sb_t r;
      r.exp = e;
      r.err = er;
`ifndef EXTP_LOADEXT_EN
      if (m >= 3'd3) begin
         r.exp = '0;
         r.err = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: compare every result the 32-bit DUT hands over.
   always @(negedge clk) begin
      sb_t e;
      if (!reset || flush) begin
         sbq.delete();
      end else if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got output %h with nothing pending, expected no output", dout);
         end else begin
            e = sbq.pop_front();
            check("sb_out", 64'(dout), e.exp);
            check("sb_err", 64'(out_err), 64'(e.err));
            pops++;
         end
      end
   end

   task automatic send(input logic [2:0] m, input logic [1:0] o, input logic [31:0] d,
                       input logic [31:0] e, input logic er);
      bit done = 1'b0;
      mode = m; off = o; din = d; in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready && reset && !flush) begin
            sbq.push_back(model_adj(m, 64'(e), er));
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send64(input string name, input logic [2:0] m, input logic [2:0] o,
                         input logic [63:0] d, input logic [63:0] e, input logic er);
      sb_t x;
      bit  seen = 1'b0;
      x = model_adj(m, e, er);
      mode64 = m; off64 = o; din64 = d; in_valid64 = 1'b1;
      @(negedge clk);
      check({name, "_ready"}, 64'(in_ready64), 64'd1);
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         if (out_valid64) begin
            seen = 1'b1;
            check(name, dout64, x.exp);
            check({name, "_err"}, 64'(out_err64), 64'(x.err));
         end
         @(posedge clk); #1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: out_valid stayed 0, expected 1 within 5 cycles", name);
      end
   endtask

   initial begin
      int base;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      din = '0; off = '0; mode = '0;
      flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
      din64 = '0; off64 = '0; mode64 = '0;

      vecs[0]  = '{EXTP_UNSIGNED, 2'd0, 32'h0000f32a, 32'h0000f32a, 1'b0};
      vecs[1]  = '{EXTP_SIGNED,   2'd0, 32'h0000f32a, 32'hfffff32a, 1'b0};
      vecs[2]  = '{EXTP_SHIFT,    2'd0, 32'h0000f32a, 32'hf32a0000, 1'b0};
      vecs[3]  = '{EXTP_SIGNED,   2'd0, 32'h00000df2, 32'h00000df2, 1'b0};
      vecs[4]  = '{EXTP_UNSIGNED, 2'd3, 32'habcd8001, 32'h00008001, 1'b0};
      vecs[5]  = '{EXTP_LB_S,     2'd0, 32'h876543a1, 32'hffffffa1, 1'b0};
      vecs[6]  = '{EXTP_LB_U,     2'd3, 32'h876543a1, 32'h00000087, 1'b0};
      vecs[7]  = '{EXTP_LH_S,     2'd2, 32'h876543a1, 32'hffff8765, 1'b0};
      vecs[8]  = '{EXTP_LH_U,     2'd1, 32'h876543a1, 32'h00000000, 1'b1};
      vecs[9]  = '{EXTP_WORD,     2'd0, 32'h876543a1, 32'h876543a1, 1'b0};
      vecs[10] = '{EXTP_WORD,     2'd2, 32'h876543a1, 32'h00000000, 1'b1};
      vecs[11] = '{EXTP_LB_U,     2'd1, 32'h876543a1, 32'h00000043, 1'b0};
      vecs[12] = '{EXTP_LH_U,     2'd0, 32'h876543a1, 32'h000043a1, 1'b0};
      vecs[13] = '{EXTP_LB_S,     2'd2, 32'h876543a1, 32'h00000065, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",    64'(out_valid), 64'd0);
      check("rst_output",   64'(dout),      64'd0);
      check("rst_error",    64'(out_err),   64'd0);
      check("rst_in_ready", 64'(in_ready),  64'd0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Latency: valid one edge after the accept edge, i.e. two cycles after presenting
      send(EXTP_UNSIGNED, 2'd0, 32'h0000f32a, 32'h0000f32a, 1'b0);
      in_valid = 1'b0;
      check("lat_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_valid", 64'(out_valid), 64'd1);
      idle(3);

      // Back-to-back table stream at full throughput
      base = pops;
      foreach (vecs[i])
         send(vecs[i].mode, vecs[i].off, vecs[i].din, vecs[i].exp, vecs[i].err);
      idle(4);
      check("table_count", 64'(pops - base), 64'(14));
      check("table_drain", 64'(sbq.size()), 64'd0);

      // Backpressure: two accepted, third stalls while the held output stays put
      base = pops;
      out_ready = 1'b0;
      send(EXTP_SIGNED,   2'd0, 32'h00008001, 32'hffff8001, 1'b0);
      send(EXTP_UNSIGNED, 2'd0, 32'h00001234, 32'h00001234, 1'b0);
      mode = EXTP_SHIFT; off = 2'd0; din = 32'h000000ab; in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("bp_in_ready",   64'(in_ready),  64'd0);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_out",   64'(dout),      64'h00000000ffff8001);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(EXTP_SHIFT, 2'd0, 32'h000000ab, 32'h00ab0000, 1'b0);
      idle(4);
      check("bp_count", 64'(pops - base), 64'(3));
      check("bp_drain", 64'(sbq.size()), 64'd0);

      // Flush with a simultaneous input beat
      base = pops;
      send(EXTP_UNSIGNED, 2'd0, 32'h00005555, 32'h00005555, 1'b0);
      mode = EXTP_SIGNED; din = 32'h00007777; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid",    64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready),  64'd1);
      @(posedge clk); #1;
      check("flush_lost", 64'(out_valid), 64'd0);
      idle(2);
      check("flush_none_out", 64'(pops - base), 64'd0);
      send(EXTP_SIGNED, 2'd0, 32'h00008000, 32'hffff8000, 1'b0);
      idle(4);
      check("flush_recover", 64'(pops - base), 64'd1);

      // Reset mid-stream with the pipeline full
      out_ready = 1'b0;
      send(EXTP_SIGNED,   2'd0, 32'h0000f32a, 32'hfffff32a, 1'b0);
      send(EXTP_UNSIGNED, 2'd0, 32'h000000ff, 32'h000000ff, 1'b0);
      in_valid = 1'b0;
      check("mrst_pre_valid", 64'(out_valid), 64'd1);
      reset = 1'b0;
      #1;
      check("mrst_in_ready_comb", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("mrst_valid",    64'(out_valid), 64'd0);
      check("mrst_output",   64'(dout),      64'd0);
      check("mrst_error",    64'(out_err),   64'd0);
      @(posedge clk); #1;
      check("mrst_in_ready", 64'(in_ready),  64'd0);
      reset = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      base = pops;
      send(EXTP_LB_S, 2'd0, 32'h876543a1, 32'hffffffa1, 1'b0);
      send(EXTP_SIGNED, 2'd0, 32'h0000f32a, 32'hfffff32a, 1'b0);
      idle(4);
      check("mrst_recover", 64'(pops - base), 64'd2);

      // 64-bit datapath
      send64("w64_shift",  EXTP_SHIFT,  3'd0, 64'h0000000000001234, 64'h1234000000000000, 1'b0);
      send64("w64_lhs6",   EXTP_LH_S,   3'd6, 64'h8000000000000000, 64'hffffffffffff8000, 1'b0);
      send64("w64_signed", EXTP_SIGNED, 3'd5, 64'hdead000000008001, 64'hffffffffffff8001, 1'b0);
      send64("w64_word4",  EXTP_WORD,   3'd4, 64'h8000000012345678, 64'hffffffff80000000, 1'b0);
      send64("w64_word2",  EXTP_WORD,   3'd2, 64'h8000000012345678, 64'h0000000000000000, 1'b1);
      send64("w64_lbu5",   EXTP_LB_U,   3'd5, 64'h00009a0000000000, 64'h000000000000009a, 1'b0);
      send64("w64_lhu3",   EXTP_LH_U,   3'd3, 64'h00009a0000000000, 64'h0000000000000000, 1'b1);

      check("final_drain", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
